// File: rtl/reg_file_sweep.sv
// Purpose: 8 x 8-bit ALU operand register file; after reset a sweep clears one register per cycle.
// Latency: reads are combinational and writes land on the rising CLK edge; the clear sweep lasts DEPTH cycles.
// Backpressure: BUSY is high while the sweep runs, and any write issued then is dropped silently.
// Optional feature: define REG_BYPASS_EN for same-cycle write-first forwarding on the read ports.

module reg_file_sweep #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WIDTH-1:0]  IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [WIDTH-1:0]  OUT1,
  output logic [WIDTH-1:0]  OUT2,
  output logic              BUSY
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic              busy_q;

  // The storage has no reset, so it can map onto a plain RAM macro; the sweep zeroes it instead.
  logic [WIDTH-1:0]  mem [DEPTH];

  logic [WIDTH-1:0]  rd1;
  logic [WIDTH-1:0]  rd2;

  // Sweep controller: reset parks the pointer at 0, and each clean edge advances it until the last entry is cleared.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_CLEAR;
      ptr    <= '0;
      busy_q <= 1'b1;
    end else if (state == ST_CLEAR) begin
      if (ptr == LAST_PTR) begin
        state  <= ST_IDLE;
        busy_q <= 1'b0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  // Storage write port: the sweep owns the port in CLEAR. A reset edge leaves the contents untouched and drops any write.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (state == ST_CLEAR) begin
        mem[ptr] <= '0;
      end else if (WRITE) begin
        mem[INADDRESS] <= IN;
      end
    end
  end

  // Read ports: stored data, optionally forwarded from the write port, forced to 0 while the sweep is in progress.
  always_comb begin
    rd1 = mem[OUT1ADDRESS];
    rd2 = mem[OUT2ADDRESS];
`ifdef REG_BYPASS_EN
    // Forward only when the write will actually land on this edge.
    if (WRITE && !RESET && (OUT1ADDRESS == INADDRESS)) begin
      rd1 = IN;
    end
    if (WRITE && !RESET && (OUT2ADDRESS == INADDRESS)) begin
      rd2 = IN;
    end
`endif
    if (busy_q) begin
      rd1 = '0;
      rd2 = '0;
    end
  end

  assign OUT1 = rd1;
  assign OUT2 = rd2;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_reg_file_sweep.sv
// Purpose: directed, table-driven bench for reg_file_sweep, with hand-written sequences for the sweep corners.
// Latency: inputs change 1 ns after each rising edge, and outputs are sampled 1 ns later.
// Backpressure: every wait on BUSY is bounded by a fixed edge budget.

module tb_reg_file_sweep;

  logic       CLK;
  logic       RESET;
  logic [7:0] IN;
  logic [2:0] INADDRESS;
  logic       WRITE;
  logic [2:0] OUT1ADDRESS;
  logic [2:0] OUT2ADDRESS;
  logic [7:0] OUT1;
  logic [7:0] OUT2;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       wr;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t vecs [11];

  reg_file_sweep dut (
    .CLK(CLK),
    .RESET(RESET),
    .IN(IN),
    .INADDRESS(INADDRESS),
    .WRITE(WRITE),
    .OUT1ADDRESS(OUT1ADDRESS),
    .OUT2ADDRESS(OUT2ADDRESS),
    .OUT1(OUT1),
    .OUT2(OUT2),
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    WRITE = 1'b1;
    INADDRESS = a;
    IN = d;
    tick();
    WRITE = 1'b0;
  endtask

  // Release reset and run a sweep. Outputs must read 0 on every busy cycle, and BUSY must fall after exp_edges edges.
  // If wr_first is nonzero, WRITE=1 to wa (data FF) is held from that sweep edge until the sweep ends.
  task automatic sweep(input string name, input int exp_edges, input int wr_first, input logic [2:0] wa);
    int n;
    n = 0;
    RESET = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      if (wr_first != 0 && e >= wr_first) begin
        WRITE = 1'b1;
        INADDRESS = wa;
        IN = 8'hFF;
      end else begin
        WRITE = 1'b0;
      end
      #1;
      check({name, " busy"}, {7'd0, BUSY}, 8'h01);
      check({name, " out1 zero"}, OUT1, 8'h00);
      check({name, " out2 zero"}, OUT2, 8'h00);
      tick();
      n = e;
      if (!BUSY) break;
    end
    WRITE = 1'b0;
    check({name, " edge count"}, 8'(n), 8'(exp_edges));
  endtask

  task automatic read_all_zero(input string name);
    for (int a = 0; a < 8; a++) begin
      OUT1ADDRESS = 3'(a);
      OUT2ADDRESS = 3'(7 - a);
      #1;
      check({name, " out1"}, OUT1, 8'h00);
      check({name, " out2"}, OUT2, 8'h00);
      tick();
    end
  endtask

  initial begin
    // Fields: wr, wa, wd, a1, a2, expected OUT1, expected OUT2 (sampled before the edge).
    vecs[0]  = '{1'b1, 3'd3, 8'h2A, 3'd0, 3'd7, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 8'h2A, 8'h2A};
    vecs[2]  = '{1'b1, 3'd1, 8'h05, 3'd3, 3'd2, 8'h2A, 8'h00};
    vecs[3]  = '{1'b1, 3'd2, 8'h0A, 3'd1, 3'd0, 8'h05, 8'h00};
    vecs[4]  = '{1'b0, 3'd0, 8'h00, 3'd1, 3'd2, 8'h05, 8'h0A};
    vecs[5]  = '{1'b0, 3'd7, 8'hEE, 3'd7, 3'd4, 8'h00, 8'h00};
    vecs[6]  = '{1'b0, 3'd0, 8'h00, 3'd7, 3'd3, 8'h00, 8'h2A};
    vecs[7]  = '{1'b1, 3'd0, 8'hC3, 3'd5, 3'd6, 8'h00, 8'h00};
    vecs[8]  = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd1, 8'hC3, 8'h05};
    vecs[9]  = '{1'b1, 3'd3, 8'h5A, 3'd2, 3'd0, 8'h0A, 8'hC3};
    vecs[10] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 8'h5A, 8'h5A};

    RESET = 1'b1;
    IN = 8'h00;
    INADDRESS = 3'd0;
    WRITE = 1'b0;
    OUT1ADDRESS = 3'd7;
    OUT2ADDRESS = 3'd0;

    // Reset held for two edges, then the initial sweep.
    tick();
    tick();
    check("reset busy", {7'd0, BUSY}, 8'h01);
    check("reset out1", OUT1, 8'h00);
    check("reset out2", OUT2, 8'h00);
    sweep("init sweep", 8, 0, 3'd0);
    read_all_zero("init clear");

    // Table-driven IDLE traffic.
    for (int i = 0; i < 11; i++) begin
      WRITE = vecs[i].wr;
      INADDRESS = vecs[i].wa;
      IN = vecs[i].wd;
      OUT1ADDRESS = vecs[i].a1;
      OUT2ADDRESS = vecs[i].a2;
      #1;
      check($sformatf("vec%0d out1", i), OUT1, vecs[i].e1);
      check($sformatf("vec%0d out2", i), OUT2, vecs[i].e2);
      check($sformatf("vec%0d busy", i), {7'd0, BUSY}, 8'h00);
      tick();
    end
    WRITE = 1'b0;

    // The ALU add of R1 and R2 must give 0F.
    OUT1ADDRESS = 3'd1;
    OUT2ADDRESS = 3'd2;
    #1;
    check("alu add sum", OUT1 + OUT2, 8'h0F);
    tick();

    // Read and write to the same address in the same cycle.
    write_reg(3'd4, 8'h11);
    WRITE = 1'b1;
    INADDRESS = 3'd4;
    IN = 8'h22;
    OUT1ADDRESS = 3'd4;
    #1;
`ifdef REG_BYPASS_EN
    check("same addr pre-edge", OUT1, 8'h22);
`else
    check("same addr pre-edge", OUT1, 8'h11);
`endif
    tick();
    WRITE = 1'b0;
    #1;
    check("same addr post-edge", OUT1, 8'h22);
    tick();

    // Write during the sweep: R3=5A and R7=99 are live before reset, so forced-zero reads are visible.
    write_reg(3'd7, 8'h99);
    OUT1ADDRESS = 3'd7;
    #1;
    check("r7 before sweep", OUT1, 8'h99);
    OUT1ADDRESS = 3'd3;
    OUT2ADDRESS = 3'd7;
    RESET = 1'b1;
    tick();
    sweep("wr sweep", 8, 3, 3'd5);
    read_all_zero("wr sweep clear");

    // Reset mid-sweep: R6 has not been cleared yet when the sweep restarts.
    write_reg(3'd6, 8'h77);
    OUT1ADDRESS = 3'd6;
    #1;
    check("r6 written", OUT1, 8'h77);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    RESET = 1'b1;
    tick();
    check("mid reset busy", {7'd0, BUSY}, 8'h01);
    sweep("restart sweep", 8, 0, 3'd0);
    OUT1ADDRESS = 3'd6;
    #1;
    check("r6 cleared", OUT1, 8'h00);
    tick();
    read_all_zero("restart clear");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sweep.md
Name: reg_file_sweep

Overview:
- 8 x 8-bit register file feeding the ALU operand inputs: OUT1 drives DATA1, OUT2 drives DATA2.
- Captures the ALU result on its write port.
- Two combinational read ports, one clocked write port.
- Storage is cleared by a one-register-per-cycle sweep state machine after reset, so the array can map to plain RAM without a per-bit reset; BUSY flags the sweep to the control unit.

Parameters:
WIDTH, 8, data width of each register and of IN/OUT1/OUT2
ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers (8 by default)

Ports:
CLK  input  1  system clock, rising-edge active
RESET  input  1  synchronous, active-high reset
IN  input  WIDTH  write data (ALU RESULT)
INADDRESS  input  ADDR_W  write register index
WRITE  input  1  write enable, sampled at rising CLK
OUT1ADDRESS  input  ADDR_W  read port 1 register index
OUT2ADDRESS  input  ADDR_W  read port 2 register index
OUT1  output  WIDTH  read port 1 data (to ALU DATA1)
OUT2  output  WIDTH  read port 2 data (to ALU DATA2)
BUSY  output  1  high while the clear sweep runs; writes are dropped

Behaviour:
- Clock and reset: one clock, CLK; RESET is synchronous and active-high.
- States:
  - CLEAR: sweep in progress.
  - IDLE: normal operation.
- Sweep pointer: ptr, ADDR_W bits.
- Reset:
  - Any rising CLK with RESET=1 sets state=CLEAR, ptr=0 and BUSY=1.
  - Register contents are untouched by the reset edge itself.
  - While RESET stays high, state and ptr hold at CLEAR/0.
- CLEAR, on each rising CLK with RESET=0:
  - reg[ptr] <= 0.
  - If ptr == DEPTH-1: state <= IDLE and BUSY <= 0.
  - Otherwise ptr <= ptr+1.
  - BUSY therefore falls on the DEPTH-th rising edge after RESET deasserts (8th by default).
- Reset mid-sweep: the sweep restarts from ptr=0. Already-cleared registers stay 0; nothing is skipped.
- IDLE write: rising CLK with WRITE=1 and RESET=0 sets reg[INADDRESS] <= IN, with #1 write delay.
- WRITE=0: no register changes.
- Writes during CLEAR, or on an edge where RESET=1, are dropped silently. There is no queueing and no error flag.
- State, ptr and BUSY update with #1 after the edge.
- Reads:
  - OUT1 = reg[OUT1ADDRESS] and OUT2 = reg[OUT2ADDRESS], combinational, #2 delay.
  - Reads re-evaluate on any change of address or stored contents.
  - Both ports may address the same register.
- While BUSY=1, OUT1 and OUT2 are forced to 0 regardless of address. The ALU therefore never sees partially cleared data.
- Reset values: BUSY=1, OUT1=0, OUT2=0. In IDLE after the sweep, all registers are 0.
- Read/write same address, same cycle: the read returns the old value until the write edge (+#1 write, +#2 read propagation), unless the optional feature is enabled.
- Address arithmetic is unsigned. ptr never exceeds DEPTH-1, and no wrap occurs during the sweep.
- Time-zero state before the first reset is undefined; the bench must apply reset before use.

Optional Feature:
- Macro: REG_BYPASS_EN.
- When defined, in IDLE with WRITE=1:
  - A read port whose address equals INADDRESS returns IN combinationally (#2), before the edge.
  - The ALU thus sees write-first data in the same cycle.
  - Bypass is suppressed while BUSY=1, so outputs stay 0.
- When undefined: no bypass logic is compiled, and reads return stored contents only.

Test Plan:
- Reset sweep:
  - Stimulus: RESET=1 for 2 edges, then 0, with OUT1ADDRESS=7.
  - Response: BUSY=1 for exactly 8 edges after deassert, then 0; OUT1=0 throughout; all 8 registers read 0 afterwards.
- Write then read:
  - Stimulus: IDLE, WRITE=1, INADDRESS=3, IN=8'h2A for one edge; then OUT1ADDRESS=3, OUT2ADDRESS=3.
  - Response: OUT1=OUT2=8'h2A #2 after the write settles; other registers remain 0.
- Dual read:
  - Stimulus: write R1=8'h05 and R2=8'h0A, then OUT1ADDRESS=1, OUT2ADDRESS=2.
  - Response: OUT1=8'h05, OUT2=8'h0A; feeding the ALU with SELECT=001 gives RESULT=8'h0F.
- Write during sweep:
  - Stimulus: assert WRITE=1, INADDRESS=5, IN=8'hFF on the 3rd sweep edge.
  - Response: write dropped; after BUSY falls, R5 reads 8'h00.
- Reset mid-sweep:
  - Stimulus: write R6=8'h77, reset, re-assert RESET after 4 sweep edges, then release.
  - Response: BUSY stays high for 8 further edges after the release; R6 reads 8'h00.
- Same-address read/write:
  - Stimulus: R4=8'h11; next cycle WRITE=1, INADDRESS=4, IN=8'h22, with OUT1ADDRESS=4 before the edge.
  - Response without REG_BYPASS_EN: OUT1=8'h11 before the edge, 8'h22 after.
  - Response with REG_BYPASS_EN: OUT1=8'h22 before the edge.
